// File: rtl/phase_down_timer.sv
// Multi-phase countdown timer with a programmable per-phase duration table.
// Optional macro PHASE_TIMER_ONESHOT_EN adds a oneshot input that stops in IDLE after the last phase.
module phase_down_timer #(
    parameter int WIDTH       = 5,
    parameter int PHASES      = 4,
    parameter int PH_BITS     = 2,
    parameter int CNT_BITS    = 2,
    parameter int DEFAULT_DUR = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                start,
    input  logic                hold,
    input  logic                cfg_we,
    input  logic [PH_BITS-1:0]  cfg_idx,
    input  logic [WIDTH-1:0]    cfg_data,
`ifdef PHASE_TIMER_ONESHOT_EN
    input  logic                oneshot,
`endif
    output logic [WIDTH-1:0]    count_out,
    output logic [PH_BITS-1:0]  phase_out,
    output logic                phase_done,
    output logic                cycle_done,
    output logic [CNT_BITS-1:0] cycle_count,
    output logic                busy,
    output logic                held
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [PH_BITS-1:0]  phase_q, phase_d;
    logic                phase_done_q, phase_done_d;
    logic                cycle_done_q, cycle_done_d;
    logic [CNT_BITS-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0]    dur_q [PHASES];
    logic [WIDTH-1:0]    dur_d [PHASES];

    logic                last_phase;
    logic [PH_BITS-1:0]  phase_nxt;

    // A zero duration still occupies one cycle.
    function automatic logic [WIDTH-1:0] eff(input logic [WIDTH-1:0] d);
        return (d == '0) ? WIDTH'(1) : d;
    endfunction

    assign last_phase = (phase_q == PH_BITS'(PHASES - 1));
    assign phase_nxt  = last_phase ? '0 : phase_q + PH_BITS'(1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        phase_d      = phase_q;
        cyc_d        = cyc_q;
        phase_done_d = 1'b0;
        cycle_done_d = 1'b0;
        dur_d        = dur_q;

        // Loads below read dur_q, so a same-edge write only affects later loads.
        if (cfg_we && (32'(cfg_idx) < PHASES))
            dur_d[cfg_idx] = cfg_data;

        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            phase_d = '0;
            cyc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        count_d = eff(dur_q[0]);
                        phase_d = '0;
                    end
                end
                S_RUN: begin
                    if (hold) begin
                        state_d = S_HOLD;
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        phase_done_d = 1'b1;
                        phase_d      = phase_nxt;
                        count_d      = eff(dur_q[phase_nxt]);
                        if (last_phase) begin
                            cycle_done_d = 1'b1;
                            cyc_d        = cyc_q + CNT_BITS'(1);
`ifdef PHASE_TIMER_ONESHOT_EN
                            if (oneshot) begin
                                state_d = S_IDLE;
                                count_d = '0;
                            end
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold)
                        state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            phase_q      <= '0;
            cyc_q        <= '0;
            phase_done_q <= 1'b0;
            cycle_done_q <= 1'b0;
            for (int i = 0; i < PHASES; i++)
                dur_q[i] <= WIDTH'(DEFAULT_DUR);
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            phase_q      <= phase_d;
            cyc_q        <= cyc_d;
            phase_done_q <= phase_done_d;
            cycle_done_q <= cycle_done_d;
            dur_q        <= dur_d;
        end
    end

    assign count_out   = count_q;
    assign phase_out   = phase_q;
    assign phase_done  = phase_done_q;
    assign cycle_done  = cycle_done_q;
    assign cycle_count = cyc_q;
    assign busy        = (state_q != S_IDLE);
    assign held        = (state_q == S_HOLD);

endmodule

// File: tb/tb_phase_down_timer.sv
// Directed bench for phase_down_timer; PH_BITS=3 so an out-of-range table index is expressible.
module tb_phase_down_timer;

    localparam int WIDTH = 5, PHASES = 4, PH_BITS = 3, CNT_BITS = 2, DEFAULT_DUR = 26;

    logic clk = 1'b0;
    logic reset, clear, start, hold, cfg_we, oneshot;
    logic [PH_BITS-1:0]  cfg_idx;
    logic [WIDTH-1:0]    cfg_data;
    logic [WIDTH-1:0]    count_out;
    logic [PH_BITS-1:0]  phase_out;
    logic                phase_done, cycle_done, busy, held;
    logic [CNT_BITS-1:0] cycle_count;

    int compared = 0;
    int mismatched = 0;

    // Per-step expectations for one full cycle with dur={3,2,4,1}, starting from count=3 in phase 0.
    int exp_cnt [10] = '{2, 1, 2, 1, 4, 3, 2, 1, 1, 3};
    int exp_ph  [10] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 0};
    int exp_pd  [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 1};

    phase_down_timer #(
        .WIDTH(WIDTH), .PHASES(PHASES), .PH_BITS(PH_BITS),
        .CNT_BITS(CNT_BITS), .DEFAULT_DUR(DEFAULT_DUR)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .hold(hold),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
`ifdef PHASE_TIMER_ONESHOT_EN
        .oneshot(oneshot),
`endif
        .count_out(count_out), .phase_out(phase_out), .phase_done(phase_done),
        .cycle_done(cycle_done), .cycle_count(cycle_count), .busy(busy), .held(held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input int p, input int pd, input int cd,
                       input int cy, input int b, input int h);
        logic [13:0] obs, expv;
        obs  = {count_out, phase_out, phase_done, cycle_done, cycle_count, busy, held};
        expv = {WIDTH'(c), PH_BITS'(p), 1'(pd), 1'(cd), CNT_BITS'(cy), 1'(b), 1'(h)};
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got cnt=%0d ph=%0d pd=%0b cd=%0b cyc=%0d busy=%0b held=%0b, want cnt=%0d ph=%0d pd=%0d cd=%0d cyc=%0d busy=%0d held=%0d",
                   tag, count_out, phase_out, phase_done, cycle_done, cycle_count, busy, held,
                   c, p, pd, cd, cy, b, h);
        end
    endtask

    task automatic run_steps(input string tag, input int from, input int to, input int cyc_before);
        for (int i = from; i <= to; i++) begin
            tick();
            chk(tag, exp_cnt[i], exp_ph[i], exp_pd[i], (i == 9) ? 1 : 0,
                (i == 9) ? ((cyc_before + 1) % 4) : cyc_before, 1, 0);
        end
    endtask

    task automatic cfg_write(input int idx, input int data);
        cfg_we = 1'b1; cfg_idx = PH_BITS'(idx); cfg_data = WIDTH'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; hold = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; oneshot = 1'b0;
        tick(); tick();
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // hold is ignored in IDLE
        hold = 1'b1; tick(); hold = 1'b0;
        chk("idle_hold", 0, 0, 0, 0, 0, 0, 0);

        // default duration after reset
        start = 1'b1; tick(); start = 1'b0;
        chk("default_dur", 26, 0, 0, 0, 0, 1, 0);
        tick();
        chk("default_dec", 25, 0, 0, 0, 0, 1, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear1", 0, 0, 0, 0, 0, 0, 0);

        cfg_write(0, 3); cfg_write(1, 2); cfg_write(2, 4); cfg_write(3, 1);
        chk("cfg_idle", 0, 0, 0, 0, 0, 0, 0);

        start = 1'b1; tick(); start = 1'b0;
        chk("start", 3, 0, 0, 0, 0, 1, 0);
        // start while busy is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", 2, 0, 0, 0, 0, 1, 0);
        run_steps("cyc1", 1, 9, 0);
        run_steps("cyc2", 0, 9, 1);
        run_steps("cyc3", 0, 9, 2);
        run_steps("cyc4_wrap", 0, 9, 3);

        // hold at count 2 in phase 2
        run_steps("pre_hold", 0, 6, 0);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", 2, 2, 0, 0, 0, 1, 1);
        end
        hold = 1'b0;
        tick(); chk("release", 2, 2, 0, 0, 0, 1, 0);
        tick(); chk("resume", 1, 2, 0, 0, 0, 1, 0);
        tick(); chk("resume_ph3", 1, 3, 1, 0, 0, 1, 0);
        tick(); chk("resume_wrap", 3, 0, 1, 1, 1, 1, 0);

        // clear in phase 1 at count 1
        run_steps("pre_clear", 0, 3, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_mid", 0, 0, 0, 0, 0, 0, 0);
        clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
        chk("clear_start", 0, 0, 0, 0, 0, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_kept", 3, 0, 0, 0, 0, 1, 0);

        // zero duration clamps to one cycle; writes never touch the running count
        cfg_write(1, 0);
        chk("wr_zero", 2, 0, 0, 0, 0, 1, 0);
        tick(); chk("z1", 1, 0, 0, 0, 0, 1, 0);
        tick(); chk("z_ph1", 1, 1, 1, 0, 0, 1, 0);
        tick(); chk("z_ph2", 4, 2, 1, 0, 0, 1, 0);
        tick(); chk("z3", 3, 2, 0, 0, 0, 1, 0);
        tick(); chk("z4", 2, 2, 0, 0, 0, 1, 0);
        tick(); chk("z5", 1, 2, 0, 0, 0, 1, 0);
        tick(); chk("z_ph3", 1, 3, 1, 0, 0, 1, 0);
        // write on the wrap edge: the load uses the old value
        cfg_write(0, 7);
        chk("wr_wrap_old", 3, 0, 1, 1, 1, 1, 0);
        cfg_write(5, 9);
        chk("wr_oob", 2, 0, 0, 0, 1, 1, 0);
        tick(); chk("n1", 1, 0, 0, 0, 1, 1, 0);
        tick(); chk("n_ph1", 1, 1, 1, 0, 1, 1, 0);
        tick(); chk("n_ph2", 4, 2, 1, 0, 1, 1, 0);
        tick(); tick(); tick();
        chk("n_ph2_end", 1, 2, 0, 0, 1, 1, 0);
        tick(); chk("n_ph3", 1, 3, 1, 0, 1, 1, 0);
        tick(); chk("wr_new", 7, 0, 1, 1, 2, 1, 0);
        tick(); chk("new_dec", 6, 0, 0, 0, 2, 1, 0);

`ifdef PHASE_TIMER_ONESHOT_EN
        oneshot = 1'b1;
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("os_start", 7, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("os_p0end", 1, 0, 0, 0, 0, 1, 0);
        tick(); chk("os_ph1", 1, 1, 1, 0, 0, 1, 0);
        tick(); chk("os_ph2", 4, 2, 1, 0, 0, 1, 0);
        tick(); tick(); tick();
        tick(); chk("os_ph3", 1, 3, 1, 0, 0, 1, 0);
        tick(); chk("os_done", 0, 0, 1, 1, 1, 0, 0);
        tick(); chk("os_idle", 0, 0, 0, 0, 1, 0, 0);
        oneshot = 1'b0;
`endif

        // reset beats a same-edge table write
        reset = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_data = WIDTH'(5);
        tick();
        reset = 1'b0; cfg_we = 1'b0;
        chk("reset2", 0, 0, 0, 0, 0, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("reset_drop_wr", 26, 0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
